rx_pkt_sequencer: RTL

Supervises the OFDM receive core for one packet at a time. It tracks each packet from the start of demodulation, through header and payload bytes, to the FCS verdict. It aborts and resets the core when the header is bad, the core stalls, or the byte count overruns. It sits beside the dot11 receive core: its core_reset output is OR'ed into the core reset, and its status and counters are exposed as AXI-lite read registers.

---
 rtl/rx_pkt_sequencer_pkg.sv | 28 ++
 rtl/rx_pkt_sequencer_sat.sv | 32 +++
 rtl/rx_pkt_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rx_pkt_sequencer_pkg.sv
// Shared types and constants for the OFDM receive packet sequencer.
package rx_pkt_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_HDR = 3'd1,
        ST_DATA     = 3'd2,
        ST_WAIT_FCS = 3'd3,
        ST_RECOVER  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE         = 3'd0,
        CAUSE_HDR_TIMEOUT  = 3'd1,
        CAUSE_HDR_BAD      = 3'd2,
        CAUSE_OVERRUN      = 3'd3,
        CAUSE_BYTE_TIMEOUT = 3'd4
    } abort_cause_e;

    localparam int unsigned DEF_HDR_TIMEOUT  = 4096;
    localparam int unsigned DEF_BYTE_TIMEOUT = 1024;
    localparam int unsigned BYTE_CNT_W       = 16;

    function automatic logic [BYTE_CNT_W-1:0] byte_cnt_next(input logic [BYTE_CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/rx_pkt_sequencer_sat.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count visible the cycle after inc_i. No backpressure.
// Backpressure: none; increments beyond all-ones are dropped.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rx_pkt_sequencer.sv
// Per-packet supervisor for the OFDM receive core: tracks header/bytes/FCS, aborts and resets the core.
// Latency: all outputs registered; strobes appear the cycle after the triggering input.
// Backpressure: none; input strobes are never stalled, and are ignored while the core is held in reset.
module rx_pkt_sequencer
    import rx_pkt_sequencer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned TIMEOUT_WIDTH = 20,
    parameter int unsigned RST_PULSE_LEN = 8
) (
    input  logic                     s00_axi_aclk,
    input  logic                     s00_axi_aresetn,
    input  logic                     enable,
    input  logic                     sw_reset,
    input  logic [TIMEOUT_WIDTH-1:0] hdr_timeout,
    input  logic [TIMEOUT_WIDTH-1:0] byte_timeout,
    input  logic                     demod_is_ongoing,
    input  logic                     pkt_header_valid_strobe,
    input  logic                     pkt_header_valid,
    input  logic                     ht_unsupport,
    input  logic [15:0]              pkt_len,
    input  logic                     byte_out_strobe,
    input  logic                     fcs_out_strobe,
    input  logic                     fcs_ok,
    output logic                     core_reset,
    output logic                     busy,
    output logic                     pkt_done_strobe,
    output logic                     pkt_done_fcs_ok,
    output logic                     abort_strobe,
    output logic [2:0]               abort_cause,
    output logic [15:0]              rx_byte_cnt,
    output logic [CNT_WIDTH-1:0]     ok_cnt,
    output logic [CNT_WIDTH-1:0]     bad_cnt,
    output logic [CNT_WIDTH-1:0]     abort_cnt,
    output logic [2:0]               state_out
);

    localparam int unsigned RW = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_PULSE_LEN - 1);

    state_e                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d, timer_run;
    logic [RW-1:0]            rst_cnt_q, rst_cnt_d;
    logic [15:0]              len_q, len_d;
    abort_cause_e             cause_q, cause_d, cause_evt;
    logic                     abort_q, abort_d, done_q, done_d, fcs_ok_q, fcs_ok_d;
    logic                     core_reset_q, core_reset_d, busy_q, busy_d;
    logic                     done_evt, abort_evt, hdr_ok, byte_inc, ok_inc, bad_inc;
    logic                     hdr_expired, byte_expired;

    assign timer_run    = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    assign hdr_expired  = (hdr_timeout  != '0) && (timer_q == hdr_timeout  - TIMEOUT_WIDTH'(1));
    assign byte_expired = (byte_timeout != '0) && (timer_q == byte_timeout - TIMEOUT_WIDTH'(1));

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            rst_cnt_q    <= '0;
            len_q        <= '0;
            cause_q      <= CAUSE_NONE;
            abort_q      <= 1'b0;
            done_q       <= 1'b0;
            fcs_ok_q     <= 1'b0;
            core_reset_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            rst_cnt_q    <= rst_cnt_d;
            len_q        <= len_d;
            cause_q      <= cause_d;
            abort_q      <= abort_d;
            done_q       <= done_d;
            fcs_ok_q     <= fcs_ok_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        rst_cnt_d = rst_cnt_q;
        len_d     = len_q;
        cause_evt = CAUSE_NONE;
        done_evt  = 1'b0;
        abort_evt = 1'b0;
        hdr_ok    = 1'b0;
        byte_inc  = 1'b0;
        if (sw_reset) begin
            state_d   = ST_RECOVER;
            rst_cnt_d = '0;
        end else if (state_q == ST_RECOVER) begin
            if (rst_cnt_q == RST_LAST) state_d = ST_IDLE;
            else                       rst_cnt_d = rst_cnt_q + 1'b1;
        end else if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (demod_is_ongoing) begin
                        state_d = ST_WAIT_HDR;
                        timer_d = '0;
                    end
                end
                ST_WAIT_HDR: begin
                    timer_d = timer_run;
                    if (pkt_header_valid_strobe) begin
                        if (pkt_header_valid && !ht_unsupport) begin
                            hdr_ok  = 1'b1;
                            len_d   = pkt_len;
                            timer_d = '0;
                            state_d = (pkt_len == '0) ? ST_WAIT_FCS : ST_DATA;
                        end else begin
                            abort_evt = 1'b1;
                            cause_evt = CAUSE_HDR_BAD;
                        end
                    end else if (hdr_expired) begin
                        abort_evt = 1'b1;
                        cause_evt = CAUSE_HDR_TIMEOUT;
                    end else if (!demod_is_ongoing) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA, ST_WAIT_FCS: begin
                    byte_inc = byte_out_strobe;
                    timer_d  = byte_out_strobe ? '0 : timer_run;
                    if (fcs_out_strobe) begin
                        done_evt = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (byte_out_strobe && (state_q == ST_WAIT_FCS)) begin
                        abort_evt = 1'b1;
                        cause_evt = CAUSE_OVERRUN;
                    // A byte arriving this cycle means the stream has not stalled.
                    end else if (!byte_out_strobe && byte_expired) begin
                        abort_evt = 1'b1;
                        cause_evt = CAUSE_BYTE_TIMEOUT;
                    end else if (byte_out_strobe && (byte_cnt_next(rx_byte_cnt) == len_q)) begin
                        state_d = ST_WAIT_FCS;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (abort_evt) begin
                state_d   = ST_RECOVER;
                rst_cnt_d = '0;
            end
        end
    end

    always_comb begin
        abort_d      = abort_evt;
        cause_d      = abort_evt ? cause_evt : cause_q;
        done_d       = done_evt;
        fcs_ok_d     = done_evt ? fcs_ok : fcs_ok_q;
        core_reset_d = (state_d == ST_RECOVER);
        busy_d       = (state_d != ST_IDLE);
        ok_inc       = done_evt && fcs_ok;
        bad_inc      = done_evt && !fcs_ok;
    end

    sat_counter #(.WIDTH(BYTE_CNT_W)) u_byte_cnt (
        .clk_i(s00_axi_aclk), .rst_ni(s00_axi_aresetn), .clr_i(hdr_ok), .inc_i(byte_inc), .cnt_o(rx_byte_cnt)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_ok_cnt (
        .clk_i(s00_axi_aclk), .rst_ni(s00_axi_aresetn), .clr_i(1'b0), .inc_i(ok_inc), .cnt_o(ok_cnt)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_bad_cnt (
        .clk_i(s00_axi_aclk), .rst_ni(s00_axi_aresetn), .clr_i(1'b0), .inc_i(bad_inc), .cnt_o(bad_cnt)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_abort_cnt (
        .clk_i(s00_axi_aclk), .rst_ni(s00_axi_aresetn), .clr_i(1'b0), .inc_i(abort_evt), .cnt_o(abort_cnt)
    );

    assign core_reset      = core_reset_q;
    assign busy            = busy_q;
    assign pkt_done_strobe = done_q;
    assign pkt_done_fcs_ok = fcs_ok_q;
    assign abort_strobe    = abort_q;
    assign abort_cause     = cause_q;
    assign state_out       = state_q;

endmodule
